spi_capture_multi: RTL and testbench
====================================

# spi_capture_multi

Parametrised multi-channel SPI ADC frame-capture engine for the senseye sensor path. Drives one shared chip select and SPI clock into NUM_CH serial ADCs in lockstep. It shifts in NUM_PIX conversions per channel after a start pulse, and emits one packed write per pixel toward the frame buffer behind the MSS fabric interface. It generalises the single-ADC capture logic: configurable channel count, sample width, lead bits, SPI clock divider, frame length, abort, and an optional test pattern.

## Interface
- NUM_CH, 2, ADCs sampled in parallel, one miso line each
- SAMPLE_W, 12, data bits kept per conversion
- LEAD_BITS, 4, leading bits clocked per conversion and discarded; FB = LEAD_BITS + SAMPLE_W
- CLK_DIV, 2, SYSCLK cycles per SPI_CLK half-period, ≥1
- CS_IDLE, 2, SYSCLK cycles cs held high between conversions, ≥1
- NUM_PIX, 112, conversions per channel per frame, ≥1
- ADDR_W, 7, pixel address width, ≥ clog2(NUM_PIX)
- SYSCLK  in  1  single clock; all logic on rising edge
- NSYSRESET  in  1  synchronous, active-low reset
- start  in  1  capture request; accepted only when busy=0
- abort  in  1  terminate frame at next edge
- miso  in  NUM_CH  ADC serial data; bit c belongs to channel c
- cs  out  1  active-low ADC chip select, shared
- SPI_CLK  out  1  ADC serial clock, idle low
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  ADDR_W  pixel index 0..NUM_PIX-1
- wr_data  out  NUM_CH*SAMPLE_W  channel c in bits [c*SAMPLE_W +: SAMPLE_W]
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse on normal frame completion
- startCaptureTP  out  1  scope test point; one-cycle pulse when start accepted

## Operation
- Reset values: cs=1, SPI_CLK=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, startCaptureTP=0; FSM in IDLE; pixel counter 0.
- States: IDLE → SETUP → SHIFT → GAP → (SETUP or IDLE).
- IDLE: start=1 and abort=0 → SETUP. Next cycle: cs=0, busy=1, startCaptureTP=1, pixel counter cleared.
- SETUP: cs low, SPI_CLK low for CLK_DIV cycles → SHIFT.
- SHIFT: FB SPI_CLK periods, each CLK_DIV cycles high then CLK_DIV low. On the SYSCLK edge ending each high phase, shift every miso bit into its channel register, MSB first. The first LEAD_BITS bits are dropped; the last SAMPLE_W bits form the sample. After the final low phase → GAP.
- GAP: cs=1 for CS_IDLE cycles. In the first GAP cycle: wr_en=1, wr_addr=pixel index, wr_data=all channel samples. wr_addr and wr_data hold until the next write.
- End of GAP: if pixel index = NUM_PIX-1 → IDLE, else increment the index → SETUP.
- abort=1 in any state: next cycle IDLE, cs=1, SPI_CLK=0, busy=0. A partial sample is never written, done is not pulsed, and wr_addr/wr_data are retained.
- start while busy=1 is ignored. start and abort in the same cycle: abort wins.
- NSYSRESET=0 mid-frame: identical to abort, and all outputs also return to their reset values.

## Timing
- Conversion period T = CLK_DIV*(1+2*FB) + CS_IDLE SYSCLK cycles; defaults give T = 68.
- start sampled at edge k → cs low and busy high from cycle k+1.
- wr_en for pixel p is high in cycle k+1 + p*T + CLK_DIV*(1+2*FB).
- done=1 and busy=0 in the same cycle, exactly NUM_PIX*T cycles after busy rises. A start in that cycle is accepted.
- Minimum cs high between frames: CS_IDLE cycles.

## Configuration
- SPI_CAPTURE_TESTPATTERN_EN
  - Defined: adds input test_pat (1 bit). When test_pat=1, channel c's field of wr_data = (pixel index + c) mod 2^SAMPLE_W. SPI/cs timing and wr_en timing are unchanged and miso is ignored. When test_pat=0, behaviour is normal.
  - Undefined: the test_pat port does not exist and wr_data always comes from miso.

## Test plan
- Defaults: miso0 streams 16'h0ABC and miso1 streams 16'h0123 per conversion → 112 wr_en pulses, addr 0..111, each wr_data = 24'h123ABC; done exactly 7616 cycles after busy rises.
- Lead bits discarded: miso held at 1 → every wr_data = 24'hFFFFFF; SPI_CLK shows 16 rising edges per cs-low window; cs high 2 cycles between conversions.
- abort asserted during SHIFT of pixel 5 → cs=1 and busy=0 next cycle; exactly 5 writes (addr 0..4); no done; a new start writes addr 0 first.
- start pulsed at pixel 20 → ignored, no startCaptureTP; start+abort together in IDLE → busy stays 0, cs stays 1.
- NSYSRESET low for one cycle mid-SHIFT → next cycle all outputs at reset values; no write.
- With SPI_CAPTURE_TESTPATTERN_EN and test_pat=1 → at addr 7, wr_data = {12'h008, 12'h007}; SPI_CLK timing identical to the miso-driven case.

Source files
------------

// File: rtl/spi_capture_multi.sv
// Multi-channel SPI ADC frame capture: one shared cs/SPI_CLK into NUM_CH ADCs, one packed write per pixel.
// Optional feature macro SPI_CAPTURE_TESTPATTERN_EN adds the test_pat input (synthetic ramp data).
module spi_capture_multi #(
    parameter int NUM_CH    = 2,
    parameter int SAMPLE_W  = 12,
    parameter int LEAD_BITS = 4,
    parameter int CLK_DIV   = 2,
    parameter int CS_IDLE   = 2,
    parameter int NUM_PIX   = 112,
    parameter int ADDR_W    = 7
) (
    input  logic                       SYSCLK,
    input  logic                       NSYSRESET,
    input  logic                       start,
    input  logic                       abort,
`ifdef SPI_CAPTURE_TESTPATTERN_EN
    input  logic                       test_pat,
`endif
    input  logic [NUM_CH-1:0]          miso,
    output logic                       cs,
    output logic                       SPI_CLK,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [NUM_CH*SAMPLE_W-1:0] wr_data,
    output logic                       busy,
    output logic                       done,
    output logic                       startCaptureTP
);
    localparam int FB      = LEAD_BITS + SAMPLE_W;
    localparam int DW      = NUM_CH * SAMPLE_W;
    localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = (FB > 1) ? $clog2(FB) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [CNT_W-1:0]  LAST_DIV  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  LAST_IDLE = CNT_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FB - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_PIX - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [DW-1:0]     sh_q, sh_d;
    logic [DW-1:0]     sh_shifted_s;
    logic [DW-1:0]     sample_s;
    logic              cs_q, cs_d;
    logic              sck_q, sck_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tp_q, tp_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;

`ifdef SPI_CAPTURE_TESTPATTERN_EN
    function automatic logic [DW-1:0] ramp_pattern(input logic [ADDR_W-1:0] pix);
        logic [DW-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            v[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(pix) + SAMPLE_W'(c);
        end
        return v;
    endfunction
`endif

    // Per-channel shift: older bits fall off the top, so only the last SAMPLE_W bits survive
    always_comb begin
        sh_shifted_s = sh_q;
        for (int c = 0; c < NUM_CH; c++) begin
            sh_shifted_s[c*SAMPLE_W +: SAMPLE_W] =
                (sh_q[c*SAMPLE_W +: SAMPLE_W] << 1) | SAMPLE_W'(miso[c]);
        end
    end

    // Source of the pixel write payload
    always_comb begin
`ifdef SPI_CAPTURE_TESTPATTERN_EN
        if (test_pat) begin
            sample_s = ramp_pattern(pix_q);
        end else begin
            sample_s = sh_q;
        end
`else
        sample_s = sh_q;
`endif
    end

    // Frame sequencer; SPI_CLK level doubles as the high/low phase marker inside SHIFT
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        pix_d     = pix_q;
        sh_d      = sh_q;
        cs_d      = cs_q;
        sck_d     = sck_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tp_d      = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            cs_d    = 1'b1;
            sck_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_SETUP;
                        cnt_d   = '0;
                        pix_d   = '0;
                        cs_d    = 1'b0;
                        busy_d  = 1'b1;
                        tp_d    = 1'b1;
                    end else begin
                        cs_d   = 1'b1;
                        sck_d  = 1'b0;
                        busy_d = 1'b0;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == LAST_DIV) begin
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                        bit_d   = '0;
                        sck_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != LAST_DIV) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (sck_q) begin
                        cnt_d = '0;
                        sck_d = 1'b0;
                        sh_d  = sh_shifted_s;
                    end else if (bit_q == LAST_BIT) begin
                        state_d   = S_GAP;
                        cnt_d     = '0;
                        cs_d      = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = pix_q;
                        wr_data_d = sample_s;
                    end else begin
                        cnt_d = '0;
                        bit_d = bit_q + BIT_W'(1);
                        sck_d = 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q != LAST_IDLE) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (pix_q == LAST_PIX) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = '0;
                        pix_d   = pix_q + ADDR_W'(1);
                        cs_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    sck_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            pix_q     <= '0;
            sh_q      <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tp_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            pix_q     <= pix_d;
            sh_q      <= sh_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tp_q      <= tp_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign cs             = cs_q;
    assign SPI_CLK        = sck_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign startCaptureTP = tp_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
endmodule

// File: tb/tb_spi_capture_multi.sv
// Self-checking bench for spi_capture_multi: an ADC model streams words on miso and a monitor records writes.
module tb_spi_capture_multi;
    localparam int NUM_CH   = 2;
    localparam int SAMPLE_W = 12;
    localparam int FB       = 16;
    localparam int NUM_PIX  = 112;
    localparam int ADDR_W   = 7;
    localparam int DW       = NUM_CH * SAMPLE_W;
    localparam int T        = 68;
    localparam int WR_LAT   = 66;

    logic SYSCLK = 1'b0;
    logic NSYSRESET = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [NUM_CH-1:0] miso = '0;
    logic cs, SPI_CLK, wr_en, busy, done, startCaptureTP;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0] wr_data;
`ifdef SPI_CAPTURE_TESTPATTERN_EN
    logic test_pat = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    spi_capture_multi dut (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .start(start), .abort(abort),
`ifdef SPI_CAPTURE_TESTPATTERN_EN
        .test_pat(test_pat),
`endif
        .miso(miso), .cs(cs), .SPI_CLK(SPI_CLK), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .startCaptureTP(startCaptureTP)
    );

    always #5 SYSCLK = ~SYSCLK;

    // ADC model and monitor state
    int mode = 0;
    logic [FB-1:0] fix_w [NUM_CH];
    logic [FB-1:0] cur_w [NUM_CH];
    int cyc = 0, busy_rise_cyc = 0, done_cnt = 0, done_cyc = 0, tp_cnt = 0;
    int wr_cnt = 0, first_wr_cyc = 0, bit_i = 0, rises = 0, cs_hi_len = 0;
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0;
    logic [ADDR_W-1:0] got_addr [$];
    logic [DW-1:0] got_data [$];
    logic [DW-1:0] exp_data [$];
    int rises_q [$];
    int gaps_q [$];

    always begin
        logic [DW-1:0] e;
        @(posedge SYSCLK);
        #1;
        cyc++;
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (startCaptureTP) tp_cnt++;
        if (wr_en) begin
            for (int c = 0; c < NUM_CH; c++) e[c*SAMPLE_W +: SAMPLE_W] = cur_w[c][SAMPLE_W-1:0];
            if (wr_cnt == 0) first_wr_cyc = cyc;
            wr_cnt++;
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            exp_data.push_back(e);
        end
        if (!cs && prev_cs) begin
            if (!startCaptureTP) gaps_q.push_back(cs_hi_len);
            for (int c = 0; c < NUM_CH; c++) begin
                cur_w[c] = (mode == 1) ? fix_w[c] : 16'($urandom());
                miso[c] = cur_w[c][FB-1];
            end
            bit_i = 0;
            rises = 0;
        end else if (!cs && prev_sck && !SPI_CLK) begin
            bit_i++;
            for (int c = 0; c < NUM_CH; c++) miso[c] = (bit_i < FB) ? cur_w[c][FB-1-bit_i] : 1'b0;
        end
        if (SPI_CLK && !prev_sck) rises++;
        if (cs && !prev_cs) rises_q.push_back(rises);
        if (cs) cs_hi_len = prev_cs ? cs_hi_len + 1 : 1;
        prev_cs = cs;
        prev_sck = SPI_CLK;
        prev_busy = busy;
    end

    task automatic clear_mon();
        got_addr.delete(); got_data.delete(); exp_data.delete();
        rises_q.delete(); gaps_q.delete();
        wr_cnt = 0; done_cnt = 0; tp_cnt = 0;
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge SYSCLK);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge SYSCLK);
        abort = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge SYSCLK);
            if (wr_cnt >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge SYSCLK);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        skip(3);
        NSYSRESET = 1'b1;
        skip(2);
        n_cmp += 8;
        if (cs !== 1'b1) begin n_err++; $display("FAIL reset_cs: got %b expected 1", cs); end
        if (SPI_CLK !== 1'b0) begin n_err++; $display("FAIL reset_sck: got %b expected 0", SPI_CLK); end
        if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        if (wr_addr !== '0) begin n_err++; $display("FAIL reset_wr_addr: got %0h expected 0", wr_addr); end
        if (wr_data !== '0) begin n_err++; $display("FAIL reset_wr_data: got %0h expected 0", wr_data); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        if (startCaptureTP !== 1'b0) begin n_err++; $display("FAIL reset_tp: got %b expected 0", startCaptureTP); end
    endtask

    task automatic test_default_frame();
        bit ok;
        clear_mon();
        mode = 1; fix_w[0] = 16'h0ABC; fix_w[1] = 16'h0123;
        pulse_start();
        wait_done(NUM_PIX * T + 200, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL frame_done_timeout: got no done expected done"); end
        n_cmp += 5;
        if (busy !== 1'b0) begin n_err++; $display("FAIL frame_busy_at_done: got %b expected 0", busy); end
        if (wr_cnt != NUM_PIX) begin n_err++; $display("FAIL frame_writes: got %0d expected %0d", wr_cnt, NUM_PIX); end
        if (done_cyc - busy_rise_cyc != NUM_PIX * T) begin
            n_err++; $display("FAIL frame_length: got %0d expected %0d", done_cyc - busy_rise_cyc, NUM_PIX * T);
        end
        if (first_wr_cyc - busy_rise_cyc != WR_LAT) begin
            n_err++; $display("FAIL first_write_latency: got %0d expected %0d", first_wr_cyc - busy_rise_cyc, WR_LAT);
        end
        if (tp_cnt != 1) begin n_err++; $display("FAIL frame_tp_count: got %0d expected 1", tp_cnt); end
        for (int i = 0; i < got_addr.size() && i < NUM_PIX; i++) begin
            n_cmp += 2;
            if (got_addr[i] !== ADDR_W'(i)) begin n_err++; $display("FAIL frame_addr[%0d]: got %0d expected %0d", i, got_addr[i], i); end
            if (got_data[i] !== 24'h123ABC) begin n_err++; $display("FAIL frame_data[%0d]: got %h expected 123abc", i, got_data[i]); end
        end
        skip(5);
    endtask

    task automatic test_random_back_to_back();
        bit ok;
        clear_mon();
        mode = 0;
        pulse_start();
        wait_done(NUM_PIX * T + 200, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rand_done_timeout: got no done expected done"); end
        start = 1'b1;
        @(negedge SYSCLK);
        start = 1'b0;
        n_cmp += 3;
        if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        if (startCaptureTP !== 1'b1) begin n_err++; $display("FAIL b2b_tp: got %b expected 1", startCaptureTP); end
        if (got_data.size() != NUM_PIX) begin n_err++; $display("FAIL rand_writes: got %0d expected %0d", got_data.size(), NUM_PIX); end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp += 2;
            if (got_data[i] !== exp_data[i]) begin n_err++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got_data[i], exp_data[i]); end
            if (got_addr[i] !== ADDR_W'(i)) begin n_err++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", i, got_addr[i], i); end
        end
        pulse_abort();
        skip(5);
    endtask

    task automatic test_lead_bits();
        bit ok;
        clear_mon();
        mode = 1; fix_w[0] = 16'hFFFF; fix_w[1] = 16'hFFFF;
        pulse_start();
        wait_writes(6, 8 * T, ok);
        pulse_abort();
        n_cmp += 3;
        if (!ok) begin n_err++; $display("FAIL lead_timeout: got %0d writes expected 6", wr_cnt); end
        if (rises_q.size() != 6) begin n_err++; $display("FAIL lead_windows: got %0d expected 6", rises_q.size()); end
        if (gaps_q.size() != 5) begin n_err++; $display("FAIL lead_gaps: got %0d expected 5", gaps_q.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== 24'hFFFFFF) begin n_err++; $display("FAIL lead_data[%0d]: got %h expected ffffff", i, got_data[i]); end
        end
        foreach (rises_q[i]) begin
            n_cmp++;
            if (rises_q[i] != FB) begin n_err++; $display("FAIL lead_sck_rises[%0d]: got %0d expected %0d", i, rises_q[i], FB); end
        end
        foreach (gaps_q[i]) begin
            n_cmp++;
            if (gaps_q[i] != 2) begin n_err++; $display("FAIL lead_cs_gap[%0d]: got %0d expected 2", i, gaps_q[i]); end
        end
        skip(5);
    endtask

    task automatic test_abort();
        bit ok;
        logic [DW-1:0] last_exp;
        clear_mon();
        mode = 0;
        pulse_start();
        wait_writes(5, 6 * T, ok);
        skip(20);
        pulse_abort();
        n_cmp += 4;
        if (!ok) begin n_err++; $display("FAIL abort_timeout: got %0d writes expected 5", wr_cnt); end
        if (cs !== 1'b1) begin n_err++; $display("FAIL abort_cs: got %b expected 1", cs); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (SPI_CLK !== 1'b0) begin n_err++; $display("FAIL abort_sck: got %b expected 0", SPI_CLK); end
        skip(200);
        n_cmp += 2;
        if (wr_cnt != 5) begin n_err++; $display("FAIL abort_writes: got %0d expected 5", wr_cnt); end
        if (done_cnt != 0) begin n_err++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
        for (int i = 0; i < got_addr.size(); i++) begin
            n_cmp += 2;
            if (got_addr[i] !== ADDR_W'(i)) begin n_err++; $display("FAIL abort_addr[%0d]: got %0d expected %0d", i, got_addr[i], i); end
            if (got_data[i] !== exp_data[i]) begin n_err++; $display("FAIL abort_data[%0d]: got %h expected %h", i, got_data[i], exp_data[i]); end
        end
        last_exp = (exp_data.size() > 0) ? exp_data[exp_data.size()-1] : '0;
        n_cmp += 2;
        if (wr_addr !== ADDR_W'(4)) begin n_err++; $display("FAIL abort_addr_hold: got %0d expected 4", wr_addr); end
        if (wr_data !== last_exp) begin n_err++; $display("FAIL abort_data_hold: got %h expected %h", wr_data, last_exp); end
        clear_mon();
        pulse_start();
        wait_writes(1, 2 * T, ok);
        n_cmp++;
        if (!ok || got_addr.size() == 0) begin n_err++; $display("FAIL restart_timeout: got %0d writes expected 1", wr_cnt); end
        else if (got_addr[0] !== '0) begin n_err++; $display("FAIL restart_addr: got %0d expected 0", got_addr[0]); end
        else begin end
        pulse_abort();
        skip(5);
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_mon();
        mode = 0;
        pulse_start();
        wait_writes(20, 21 * T, ok);
        skip(10);
        pulse_start();
        n_cmp += 3;
        if (!ok) begin n_err++; $display("FAIL ignore_timeout: got %0d writes expected 20", wr_cnt); end
        if (startCaptureTP !== 1'b0) begin n_err++; $display("FAIL ignore_tp: got %b expected 0", startCaptureTP); end
        if (busy !== 1'b1) begin n_err++; $display("FAIL ignore_busy: got %b expected 1", busy); end
        wait_writes(22, 3 * T, ok);
        n_cmp += 2;
        if (!ok) begin n_err++; $display("FAIL ignore_timeout2: got %0d writes expected 22", wr_cnt); end
        if (tp_cnt != 1) begin n_err++; $display("FAIL ignore_tp_count: got %0d expected 1", tp_cnt); end
        for (int i = 0; i < got_addr.size(); i++) begin
            n_cmp++;
            if (got_addr[i] !== ADDR_W'(i)) begin n_err++; $display("FAIL ignore_addr[%0d]: got %0d expected %0d", i, got_addr[i], i); end
        end
        pulse_abort();
        skip(5);
        start = 1'b1; abort = 1'b1;
        @(negedge SYSCLK);
        start = 1'b0; abort = 1'b0;
        n_cmp += 3;
        if (busy !== 1'b0) begin n_err++; $display("FAIL start_abort_busy: got %b expected 0", busy); end
        if (cs !== 1'b1) begin n_err++; $display("FAIL start_abort_cs: got %b expected 1", cs); end
        if (startCaptureTP !== 1'b0) begin n_err++; $display("FAIL start_abort_tp: got %b expected 0", startCaptureTP); end
        skip(5);
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        mode = 0;
        pulse_start();
        wait_writes(3, 4 * T, ok);
        skip(15);
        NSYSRESET = 1'b0;
        @(negedge SYSCLK);
        NSYSRESET = 1'b1;
        n_cmp += 9;
        if (!ok) begin n_err++; $display("FAIL rst_mid_timeout: got %0d writes expected 3", wr_cnt); end
        if (cs !== 1'b1) begin n_err++; $display("FAIL rst_mid_cs: got %b expected 1", cs); end
        if (SPI_CLK !== 1'b0) begin n_err++; $display("FAIL rst_mid_sck: got %b expected 0", SPI_CLK); end
        if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_wr_en: got %b expected 0", wr_en); end
        if (wr_addr !== '0) begin n_err++; $display("FAIL rst_mid_wr_addr: got %0h expected 0", wr_addr); end
        if (wr_data !== '0) begin n_err++; $display("FAIL rst_mid_wr_data: got %0h expected 0", wr_data); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        if (startCaptureTP !== 1'b0) begin n_err++; $display("FAIL rst_mid_tp: got %b expected 0", startCaptureTP); end
        skip(100);
        n_cmp++;
        if (wr_cnt != 3) begin n_err++; $display("FAIL rst_mid_writes: got %0d expected 3", wr_cnt); end
    endtask

`ifdef SPI_CAPTURE_TESTPATTERN_EN
    task automatic test_pattern();
        bit ok;
        logic [DW-1:0] e;
        clear_mon();
        mode = 0;
        test_pat = 1'b1;
        pulse_start();
        wait_writes(8, 9 * T, ok);
        pulse_abort();
        test_pat = 1'b0;
        n_cmp += 2;
        if (!ok) begin n_err++; $display("FAIL tpat_timeout: got %0d writes expected 8", wr_cnt); end
        if (first_wr_cyc - busy_rise_cyc != WR_LAT) begin
            n_err++; $display("FAIL tpat_latency: got %0d expected %0d", first_wr_cyc - busy_rise_cyc, WR_LAT);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            e = {12'(i + 1), 12'(i)};
            n_cmp++;
            if (got_data[i] !== e) begin n_err++; $display("FAIL tpat_data[%0d]: got %h expected %h", i, got_data[i], e); end
        end
        foreach (rises_q[i]) begin
            n_cmp++;
            if (rises_q[i] != FB) begin n_err++; $display("FAIL tpat_sck_rises[%0d]: got %0d expected %0d", i, rises_q[i], FB); end
        end
        skip(5);
    endtask
`endif

    initial begin
        fix_w[0] = '0; fix_w[1] = '0;
        cur_w[0] = '0; cur_w[1] = '0;
        test_reset();
        test_default_frame();
        test_random_back_to_back();
        test_lead_bits();
        test_abort();
        test_start_ignored();
        test_reset_mid();
`ifdef SPI_CAPTURE_TESTPATTERN_EN
        test_pattern();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
